popcount_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares one bus population-count (set-bit count) datapath among NREQ requesters. Each requester presents a WIDTH-bit word with a valid/ready handshake. One grant is issued per cycle. The granted word's popcount is registered into a single output stage, tagged with the requester index. A running total of all counted ones is kept for statistics. The block sits between client ports and downstream consumers of popcount results.

---
 rtl/popcount_arbiter.sv | 142 ++++++++++++++
 tb/tb_popcount_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_arbiter.sv
// popcount_arbiter
//
// Shares one population-count datapath among NREQ requesters. A combinational
// round-robin search picks one pending requester per cycle; the popcount of its
// word is registered into a single output stage tagged with the requester
// index. A running total of all counted ones is kept for statistics.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous, active-low reset
//   req_valid  [NREQ]        requester i has a word pending
//   req_data   [NREQ*WIDTH]  word of requester i at [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        one-hot grant, or zero
//   out_valid                output stage holds a result (this is the FSM state)
//   out_ready                consumer takes the result this cycle
//   out_sum    [$clog2(WIDTH)+1]  set-bit count of the granted word
//   out_id     [$clog2(NREQ)]     index of the granted requester
//   sum_clr                  synchronous clear of total (wins over a capture)
//   total      [CNT_W]       running sum of captured out_sum values, wrapping
//
// Handshake: a word moves on any edge where req_valid[i] & req_ready[i]; a
// result leaves on any edge where out_valid & out_ready. Valid never waits on
// ready; ready may depend combinationally on valid, never on data.

module popcount_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH):0]     out_sum,
  output logic [$clog2(NREQ)-1:0]    out_id,
  input  logic                       sum_clr,
  output logic [CNT_W-1:0]           total
);

  localparam int SW = $clog2(WIDTH) + 1;
  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;

  logic            open;
  logic            found;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   next_ptr;
  logic [WIDTH-1:0] win_word;
  logic [SW-1:0]   win_pop;
  logic            take;

  // The stage state is visible to the outside world as out_valid.
  assign out_valid = (state == FULL);

  // Stage can take a word when empty or when its current result leaves now.
  assign open = (state == EMPTY) || out_ready;

  // Round-robin search: first valid index at or after ptr, with wrap-around.
  always_comb begin
    int idx;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = idx[IW-1:0];
      end
    end
  end

  // rstn gates the grant so nothing is offered while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (rstn && open && found)
      req_ready[win_id] = 1'b1;
  end

  assign take = |req_ready;

  assign next_ptr = (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  // Popcount of the selected word; result range 0..WIDTH fits in SW bits.
  assign win_word = req_data[win_id*WIDTH +: WIDTH];

  always_comb begin
    win_pop = '0;
    for (int b = 0; b < WIDTH; b++)
      win_pop = win_pop + SW'(win_word[b]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= EMPTY;
      ptr     <= '0;
      out_sum <= '0;
      out_id  <= '0;
      total   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (take) begin
            state   <= FULL;
            out_sum <= win_pop;
            out_id  <= win_id;
            ptr     <= next_ptr;
          end
        end
        FULL: begin
          // Back-to-back capture when the current result leaves and a new
          // word is granted; otherwise drain, or hold under backpressure.
          if (take) begin
            out_sum <= win_pop;
            out_id  <= win_id;
            ptr     <= next_ptr;
          end else if (out_ready) begin
            state   <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase

      // Clear wins over a same-cycle capture; that capture is not added.
      if (sum_clr)
        total <= '0;
      else if (take)
        total <= total + CNT_W'(win_pop);
    end
  end

endmodule

// File: tb/tb_popcount_arbiter.sv
// Bench for popcount_arbiter: directed scenarios plus randomized traffic, all
// checked against a round-robin reference model and a result scoreboard.
// A second instance with a 4-bit total shares the stimulus to exercise wrap.

module tb_popcount_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data  = '0;
  logic                  out_ready = 1'b0;
  logic                  sum_clr   = 1'b0;

  logic [NREQ-1:0] req_ready,   req_ready_b;
  logic            out_valid,   out_valid_b;
  logic [3:0]      out_sum,     out_sum_b;
  logic [1:0]      out_id,      out_id_b;
  logic [15:0]     total;
  logic [3:0]      total_b;

  popcount_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id), .sum_clr(sum_clr), .total(total)
  );

  popcount_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(4)) dut_w (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_id(out_id_b), .sum_clr(sum_clr), .total(total_b)
  );

  // ---------------- scoreboard / model state ----------------
  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];   // {id, sum} of each captured result, in order

  bit          m_valid = 1'b0;
  int          m_sum   = 0;
  int          m_id    = 0;
  int          m_ptr   = 0;
  int unsigned m_total = 0;
  int          last_grant = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int w;
    logic [NREQ-1:0] r;
    w = pick(req_valid, m_ptr);
    r = '0;
    if (rstn && (!m_valid || out_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_sum   = 0;
    m_id    = 0;
    m_ptr   = 0;
    m_total = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    req_data[i*WIDTH +: WIDTH] = w;
  endtask

  // One clock cycle: check outputs against the model at mid-cycle, then
  // advance the model across the rising edge. Ends on the next falling edge.
  task automatic step();
    logic [NREQ-1:0] er;
    logic [5:0] e;
    int w;
    #1;
    er = model_ready();
    check("req_ready", req_ready, er);
    check("req_ready_w", req_ready_b, er);
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_sum", out_sum, m_sum);
      check("out_id", out_id, m_id);
    end
    check("total", total, m_total % 65536);
    check("total_w", total_b, m_total % 16);
    if (m_valid && out_ready) begin
      check("sb_depth", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_result", {out_id, out_sum}, e);
      end
    end
    w = pick(req_valid, m_ptr);
    @(posedge clk);
    if (er != '0) begin
      m_sum   = $countones(req_data[w*WIDTH +: WIDTH]);
      m_id    = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % NREQ;
      exp_q.push_back({2'(w), 4'(m_sum)});
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (sum_clr) m_total = 0;
    else if (er != '0) m_total = m_total + m_sum;
    last_grant = (er != '0) ? w : -1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]  hold_sum;
  logic [1:0]  hold_id;
  logic [15:0] hold_total;

  initial begin
    // Reset state, with requests already asserted
    req_valid = 4'b1111;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_id", out_id, 0);
    check("rst_total", total, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    rstn = 1'b1;
    model_reset();

    // Single request
    set_word(2, 8'hB5);
    req_valid = 4'b0100;
    out_ready = 1'b1;
    #1 check("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    #1;
    check("single_valid", out_valid, 1);
    check("single_sum", out_sum, 5);
    check("single_id", out_id, 2);
    check("single_total", total, 5);

    // Zero word from requester 3 brings ptr back to 0
    set_word(3, 8'h00);
    req_valid = 4'b1000;
    step();
    #1;
    check("zero_sum", out_sum, 0);
    check("zero_id", out_id, 3);

    // Fairness: all valid, grants 0,1,2,3,0,1 with no bubble
    set_word(0, 8'hFF);
    set_word(1, 8'h0F);
    set_word(2, 8'hB5);
    set_word(3, 8'h01);
    req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      step();
      #1;
      check("fair_id", out_id, g % NREQ);
      check("fair_valid", out_valid, 1);
      if (g == 0) check("ff_sum", out_sum, 8);
    end

    // Backpressure for 3 cycles (ptr now 2)
    out_ready = 1'b0;
    #1;
    hold_sum   = out_sum;
    hold_id    = out_id;
    hold_total = total;
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_ready", req_ready, 0);
      step();
    end
    #1;
    check("bp_sum", out_sum, hold_sum);
    check("bp_id", out_id, hold_id);
    check("bp_total", total, hold_total);
    out_ready = 1'b1;
    #1 check("bp_release", req_ready, 4'b0100);
    step();

    // Skip idle requesters, and clear colliding with a capture
    req_valid = 4'b1000;
    step();
    req_valid = 4'b1010;
    sum_clr = 1'b1;
    #1 check("skip_ready", req_ready, 4'b0010);
    step();
    sum_clr = 1'b0;
    #1;
    check("skip_id", out_id, 1);
    check("clr_total", total, 0);

    // Wrap of a 4-bit total: 8 + 4 = C, then + 8 -> 4
    req_valid = 4'b0001;
    set_word(0, 8'hFF);
    step();
    set_word(0, 8'h0F);
    step();
    #1 check("pre_wrap_w", total_b, 4'hC);
    set_word(0, 8'hFF);
    step();
    #1;
    check("wrap_total_w", total_b, 4'h4);
    check("wrap_total", total, 20);

    // Randomized traffic; requesters hold their word until granted
    req_valid = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_word(i, 8'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      sum_clr   = ($urandom_range(0, 15) == 0);
      step();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
    end
    sum_clr = 1'b0;

    // Reset mid-operation with a held result
    req_valid = 4'b0001;
    set_word(0, 8'h3C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    req_valid = 4'b1001;
    #1 check("pre_rst_valid", out_valid, 1);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_total", total, 0);
    check("async_rst_total_w", total_b, 0);
    check("async_rst_ready", req_ready, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    #1 check("post_rst_ready", req_ready, 4'b0001);
    step();
    #1 check("post_rst_id", out_id, 0);
    req_valid = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
